// File: rtl/frog_pkg.sv
// Shared frog constants: screen geometry, direction and state encodings.
package frog_pkg;

  localparam int unsigned FROG_SIZE = 32;
  localparam int unsigned H_MAX     = 640;
  localparam int unsigned V_MAX     = 480;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned SCORE_W = 8;

  localparam int unsigned X_LIM = H_MAX - FROG_SIZE;
  localparam int unsigned Y_LIM = V_MAX - FROG_SIZE;

  typedef logic [2:0] dir_t;
  localparam dir_t DIR_NONE  = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_DOWN  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_RIGHT = 3'd4;

  localparam logic [1:0] ST_ALIVE   = 2'd0;
  localparam logic [1:0] ST_DEAD    = 2'd1;
  localparam logic [1:0] ST_RESPAWN = 2'd2;

  // Resolve same-cycle presses: up > down > left > right.
  function automatic dir_t press_priority(input logic up, input logic down,
                                          input logic left, input logic right);
    dir_t d;
    d = DIR_NONE;
    if (up)         d = DIR_UP;
    else if (down)  d = DIR_DOWN;
    else if (left)  d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/frog_controller_button_debouncer.sv
// Per-button synchronizer, debounce counter and press-edge pulse.
// Raw level to press pulse latency is DEBOUNCE_CYCLES+3 clocks.
module button_debouncer
  import frog_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, accept a level after a full stable window, then edge-detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q2;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      level_d <= level_q;
      press   <= level_q & ~level_d;
    end
  end

endmodule

// File: rtl/frog_controller.sv
// Frog position controller: debounced buttons -> frame-synchronous hops,
// bounds, cooldown, death/respawn and goal scoring.
// Optional macro FROG_WRAP_EN: horizontal moves wrap instead of blocking.
module frog_controller
  import frog_pkg::*;
#(
  parameter int unsigned STEP            = 32,
  parameter int unsigned START_X         = 304,
  parameter int unsigned START_Y         = 448,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOP_FRAMES      = 8,
  parameter int unsigned DEAD_FRAMES     = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               frame_tick,
  input  logic               collision,
  output logic [POS_W-1:0]   frog_x,
  output logic [POS_W-1:0]   frog_y,
  output logic               frog_alive,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned COOL_W = (HOP_FRAMES > 0)  ? $clog2(HOP_FRAMES + 1)  : 1;
  localparam int unsigned DEAD_W = (DEAD_FRAMES > 0) ? $clog2(DEAD_FRAMES + 1) : 1;

  localparam logic [ARITH_W-1:0] STEP_A  = ARITH_W'(STEP);
  localparam logic [ARITH_W-1:0] X_LIM_A = ARITH_W'(X_LIM);
  localparam logic [ARITH_W-1:0] Y_LIM_A = ARITH_W'(Y_LIM);

  logic               press_up, press_down, press_left, press_right;
  dir_t               press_dir;

  logic [1:0]         state_q, state_nxt;
  logic [POS_W-1:0]   x_nxt, y_nxt;
  logic               alive_nxt;
  logic [SCORE_W-1:0] score_nxt;
  dir_t               pend_q, pend_nxt;
  logic [COOL_W-1:0]  cool_q, cool_nxt;
  logic [DEAD_W-1:0]  dead_q, dead_nxt;
  logic               goal_q, goal_nxt;
  logic [ARITH_W-1:0] x_a, y_a;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .press(press_up));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .press(press_down));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn(btn_left), .press(press_left));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn(btn_right), .press(press_right));

  assign press_dir = press_priority(press_up, press_down, press_left, press_right);
  assign x_a       = {1'b0, frog_x};
  assign y_a       = {1'b0, frog_y};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ALIVE;
      frog_x     <= POS_W'(START_X);
      frog_y     <= POS_W'(START_Y);
      frog_alive <= 1'b1;
      score      <= '0;
      pend_q     <= DIR_NONE;
      cool_q     <= '0;
      dead_q     <= '0;
      goal_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      frog_x     <= x_nxt;
      frog_y     <= y_nxt;
      frog_alive <= alive_nxt;
      score      <= score_nxt;
      pend_q     <= pend_nxt;
      cool_q     <= cool_nxt;
      dead_q     <= dead_nxt;
      goal_q     <= goal_nxt;
    end
  end

  // Next-state: hop application, pending capture, death and respawn.
  always_comb begin
    state_nxt = state_q;
    x_nxt     = frog_x;
    y_nxt     = frog_y;
    alive_nxt = frog_alive;
    score_nxt = score;
    pend_nxt  = pend_q;
    cool_nxt  = cool_q;
    dead_nxt  = dead_q;
    goal_nxt  = goal_q;

    if (frame_tick && (cool_q != '0)) cool_nxt = cool_q - 1'b1;

    case (state_q)
      ST_ALIVE: begin
        if (collision) begin
          // Collision beats any same-cycle move or goal.
          state_nxt = ST_DEAD;
          alive_nxt = 1'b0;
          pend_nxt  = DIR_NONE;
          goal_nxt  = 1'b0;
          dead_nxt  = DEAD_W'(DEAD_FRAMES);
        end else begin
          if (frame_tick && goal_q) begin
            x_nxt    = POS_W'(START_X);
            y_nxt    = POS_W'(START_Y);
            goal_nxt = 1'b0;
          end else if (frame_tick && (pend_q != DIR_NONE)) begin
            pend_nxt = DIR_NONE;
            case (pend_q)
              DIR_UP: begin
                if (y_a >= STEP_A) begin
                  y_nxt    = POS_W'(y_a - STEP_A);
                  cool_nxt = COOL_W'(HOP_FRAMES);
                  if (y_a == STEP_A) begin
                    score_nxt = score + 1'b1;
                    goal_nxt  = 1'b1;
                  end
                end
              end
              DIR_DOWN: begin
                if ((y_a + STEP_A) <= Y_LIM_A) begin
                  y_nxt    = POS_W'(y_a + STEP_A);
                  cool_nxt = COOL_W'(HOP_FRAMES);
                end
              end
              DIR_LEFT: begin
                if (x_a >= STEP_A) begin
                  x_nxt    = POS_W'(x_a - STEP_A);
                  cool_nxt = COOL_W'(HOP_FRAMES);
                end else begin
`ifdef FROG_WRAP_EN
                  x_nxt    = POS_W'(X_LIM_A);
                  cool_nxt = COOL_W'(HOP_FRAMES);
`else
                  x_nxt    = frog_x;
`endif
                end
              end
              DIR_RIGHT: begin
                if ((x_a + STEP_A) <= X_LIM_A) begin
                  x_nxt    = POS_W'(x_a + STEP_A);
                  cool_nxt = COOL_W'(HOP_FRAMES);
                end else begin
`ifdef FROG_WRAP_EN
                  x_nxt    = '0;
                  cool_nxt = COOL_W'(HOP_FRAMES);
`else
                  x_nxt    = frog_x;
`endif
                end
              end
              default: ;
            endcase
          end
          // Capture at most one hop, only when idle and not cooling down.
          if ((pend_q == DIR_NONE) && (cool_q == '0) && (press_dir != DIR_NONE))
            pend_nxt = press_dir;
        end
      end
      ST_DEAD: begin
        if (dead_q == '0) begin
          state_nxt = ST_RESPAWN;
        end else if (frame_tick) begin
          dead_nxt = dead_q - 1'b1;
          if (dead_q == DEAD_W'(1)) state_nxt = ST_RESPAWN;
        end
      end
      ST_RESPAWN: begin
        if (frame_tick) begin
          x_nxt     = POS_W'(START_X);
          y_nxt     = POS_W'(START_Y);
          alive_nxt = 1'b1;
          state_nxt = ST_ALIVE;
        end
      end
      default: begin
        state_nxt = ST_ALIVE;
      end
    endcase
  end

endmodule

// File: doc/frog_controller.md
Name: frog_controller

Overview:
- Upstream stage of the frog sprite renderer. Turns the four raw board buttons into the frog's on-screen position (frog_x, frog_y), which the renderer consumes directly.
- Each button goes through sync, debounce and press-edge detection. Hops are queued and applied only on the frame tick (vertical blank), so the sprite never tears mid-frame.
- Handles screen bounds, hop cooldown, collision death/respawn and a goal-reached score.

Parameters:
- STEP, 32, hop distance in pixels; equals the sprite size.
- FROG_SIZE, 32, sprite edge in pixels.
- H_MAX, 640, visible width.
- V_MAX, 480, visible height.
- START_X, 304, respawn x (multiple of 16).
- START_Y, 448, respawn y (bottom lane).
- DEBOUNCE_CYCLES, 250000, stable-clock count before a button level is accepted (10 ms at 25 MHz).
- HOP_FRAMES, 8, frame ticks of cooldown after a hop.
- DEAD_FRAMES, 60, frame ticks the frog is held dead before respawn.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, reset, asynchronous active-low.
- btn_up, in, 1, raw button, active-high, asynchronous to clk.
- btn_down, in, 1, raw button, active-high, asynchronous to clk.
- btn_left, in, 1, raw button, active-high, asynchronous to clk.
- btn_right, in, 1, raw button, active-high, asynchronous to clk.
- frame_tick, in, 1, one-cycle pulse at start of vertical blank.
- collision, in, 1, level from hazard logic; sampled only while ALIVE.
- frog_x, out, 10, sprite left edge.
- frog_y, out, 10, sprite top edge.
- frog_alive, out, 1, high when frog is drawn and controllable.
- score, out, 8, goals reached; wraps 255->0.

Behaviour:
- Reset values (async, on rst_n low): frog_x=START_X, frog_y=START_Y, frog_alive=1, score=0, state=ALIVE, all debouncers cleared, no pending hop, cooldown=0.
- Input path, per button:
  - 2-flop synchronizer, then debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new value; any bounce restarts the counter.
  - Rising edge of the accepted level gives a 1-cycle press pulse.
  - Latency from a stable raw level to the press pulse is DEBOUNCE_CYCLES+3 clk.
- Pending hop register:
  - Holds one direction. Set by a press pulse only while ALIVE, cooldown==0 and nothing is already pending.
  - Further presses are dropped while pending or cooling down; there is no queueing beyond one.
  - Simultaneous presses in the same cycle resolve with priority up > down > left > right.
- On frame_tick in ALIVE with a hop pending, the move is applied, pending is cleared and cooldown is set to HOP_FRAMES:
  - up: y-=STEP, blocked if y<STEP.
  - down: y+=STEP, blocked if y+STEP > V_MAX-FROG_SIZE.
  - left: x-=STEP, blocked if x<STEP.
  - right: x+=STEP, blocked if x+STEP > H_MAX-FROG_SIZE.
  - A blocked move still clears pending but does not start cooldown.
  - Arithmetic is 11-bit internally; outputs are always within [0, H_MAX-FROG_SIZE] x [0, V_MAX-FROG_SIZE].
- Cooldown decrements on each frame_tick while nonzero.
- Goal: when an applied up-move gives y==0, score increments, and on the next frame_tick position returns to START_X/START_Y.
- State machine:
  - ALIVE: collision==1 on any cycle -> DEAD. frog_alive drops the next cycle, pending is cleared and the death counter is set to DEAD_FRAMES.
  - DEAD: buttons ignored, position frozen, counter decrements per frame_tick. At 0 -> RESPAWN.
  - RESPAWN: on the next frame_tick, position := START, frog_alive := 1 -> ALIVE.
  - Collision in DEAD or RESPAWN is ignored.
- Simultaneous events:
  - Collision and frame_tick with a pending hop in the same cycle: collision wins; no move, no score.
  - Goal and collision in the same cycle: collision wins.
- Reset mid-hop or while DEAD returns immediately to the reset values.

Optional Feature:
- Macro: FROG_WRAP_EN.
- Defined: left/right moves wrap horizontally instead of blocking. x<STEP going left gives x = H_MAX-FROG_SIZE; going right past H_MAX-FROG_SIZE gives x=0. Wrapped moves start cooldown.
- Undefined: left/right moves are blocked at the edges as described above.
- Vertical movement is never affected.

Decomposition:
- Package frog_pkg holds:
  - FROG_SIZE, H_MAX, V_MAX, shared with the renderer.
  - Direction encoding: NONE, UP, DOWN, LEFT, RIGHT.
  - State encoding: ALIVE, DEAD, RESPAWN.
- Sub-module button_debouncer (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES), instantiated 4x.

Test Plan:
- Reset check: hold rst_n=0 -> frog_x=304, frog_y=448, frog_alive=1, score=0. Then bench DEBOUNCE_CYCLES=4; press btn_up and wait one frame_tick -> frog_y=416, cooldown active.
- Bounce and cooldown: btn_left toggling every 2 clk for 20 clk, then stable -> exactly one hop, x=272. A second press during cooldown is dropped; after 8 ticks a press gives x=240.
- Priority and bounds: up+right in the same cycle -> y moves only. With x=608, press right -> x stays 608, no cooldown. Under FROG_WRAP_EN the same press gives x=0.
- Goal: walk up from y=448 over 14 hops -> at y=0 score=1; next frame_tick gives x=304, y=448.
- Collision race: pulse collision in the same cycle as frame_tick with a pending hop -> no move, frog_alive=0 next cycle; after 60 ticks plus 1 -> frog_alive=1 at start position.
- Reset while DEAD: assert rst_n=0 asynchronously mid-clock -> outputs return to reset values immediately, without waiting for a clk edge.
